// File: rtl/security_code_capture.sv
// Code-entry controller: debounced confirm/clear, 4-bit code compare, grant/deny, display select.
// Optional lockout after repeated failures is built when SECCODE_LOCKOUT_EN is defined.
module security_code_capture #(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          SCAN_DIV        = 8,
    parameter int          MAX_TRIES       = 3,
    parameter int          LOCK_CYCLES     = 16,
    parameter logic [3:0]  RESET_CODE      = 4'b1010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_code,
    input  logic       btn_confirm,
    input  logic       btn_clear,
    input  logic       prog,
    output logic [3:0] entered_code,
    output logic [3:0] stored_code,
    output logic       sel,
    output logic       granted,
    output logic       deny,
    output logic       alarm,
    output logic [1:0] attempts
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    if (DEBOUNCE_CYCLES < 1 || SCAN_DIV < 1 || LOCK_CYCLES < 1 ||
        MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_params
        $error("security_code_capture: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_GRANT,
        S_DENY
`ifdef SECCODE_LOCKOUT_EN
        , S_LOCKOUT
`endif
    } state_t;

    state_t state;

    // Index 0 = confirm, 1 = clear.
    logic [1:0]           sync_meta;
    logic [1:0]           sync_q;
    logic [1:0]           fired;
    logic [1:0]           accept;
    logic [1:0][DB_W-1:0] db_cnt;

    logic [SCAN_W-1:0]    scan_cnt;
    logic [1:0]           att_inc;

    logic conf_acc;
    logic clr_acc;

    assign conf_acc = accept[0];
    assign clr_acc  = accept[1];
    assign att_inc  = (attempts == 2'd3) ? 2'd3 : attempts + 2'd1;

    // One pulse per press: after firing, a button stays silent until its synchronized level drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            fired     <= '0;
            accept    <= '0;
            db_cnt    <= '0;
        end else begin
            sync_meta <= {btn_clear, btn_confirm};
            sync_q    <= sync_meta;
            for (int i = 0; i < 2; i++) begin
                accept[i] <= 1'b0;
                if (!sync_q[i]) begin
                    db_cnt[i] <= '0;
                    fired[i]  <= 1'b0;
                end else if (!fired[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        accept[i] <= 1'b1;
                        fired[i]  <= 1'b1;
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            sel      <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            sel      <= ~sel;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef SECCODE_LOCKOUT_EN
    localparam int             LOCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES);
    localparam logic [1:0]     MAX_T     = 2'(MAX_TRIES);

    logic              alarm_q;
    logic [LOCK_W-1:0] lock_cnt;

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

    // Flags are set on the transition into their state so they stay registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            entered_code <= '0;
            stored_code  <= RESET_CODE;
            granted      <= 1'b0;
            deny         <= 1'b0;
            attempts     <= '0;
`ifdef SECCODE_LOCKOUT_EN
            alarm_q      <= 1'b0;
            lock_cnt     <= '0;
`endif
        end else begin
            deny <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clr_acc) begin
                        entered_code <= '0;
                    end else if (conf_acc) begin
                        entered_code <= sw_code;
                        state        <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (entered_code == stored_code) begin
                        attempts <= '0;
                        granted  <= 1'b1;
                        state    <= S_GRANT;
                    end else begin
                        attempts <= att_inc;
`ifdef SECCODE_LOCKOUT_EN
                        if (att_inc == MAX_T) begin
                            alarm_q  <= 1'b1;
                            lock_cnt <= LOCK_LOAD;
                            state    <= S_LOCKOUT;
                        end else begin
                            deny  <= 1'b1;
                            state <= S_DENY;
                        end
`else
                        deny  <= 1'b1;
                        state <= S_DENY;
`endif
                    end
                end
                S_GRANT: begin
                    if (clr_acc) begin
                        granted <= 1'b0;
                        state   <= S_IDLE;
                    end else if (conf_acc && prog) begin
                        stored_code <= sw_code;
                    end
                end
                S_DENY: begin
                    state <= S_IDLE;
                end
`ifdef SECCODE_LOCKOUT_EN
                S_LOCKOUT: begin
                    if (lock_cnt == LOCK_W'(1)) begin
                        alarm_q  <= 1'b0;
                        attempts <= '0;
                        lock_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_security_code_capture.sv
// Bench for security_code_capture: vector table plus event scoreboard; covers both
// builds of SECCODE_LOCKOUT_EN.
module tb_security_code_capture;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int SCAN_DIV        = 8;
    localparam int MAX_TRIES       = 3;
    localparam int LOCK_CYCLES     = 16;

    localparam logic [1:0] EV_NONE  = 2'd0;
    localparam logic [1:0] EV_GRANT = 2'd1;
    localparam logic [1:0] EV_DENY  = 2'd2;
    localparam logic [1:0] EV_ALARM = 2'd3;

    logic       clk;
    logic       reset;
    logic [3:0] sw_code;
    logic       btn_confirm;
    logic       btn_clear;
    logic       prog;
    logic [3:0] entered_code;
    logic [3:0] stored_code;
    logic       sel;
    logic       granted;
    logic       deny;
    logic       alarm;
    logic [1:0] attempts;

    security_code_capture #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SCAN_DIV       (SCAN_DIV),
        .MAX_TRIES      (MAX_TRIES),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .RESET_CODE     (4'b1010)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_code     (sw_code),
        .btn_confirm (btn_confirm),
        .btn_clear   (btn_clear),
        .prog        (prog),
        .entered_code(entered_code),
        .stored_code (stored_code),
        .sel         (sel),
        .granted     (granted),
        .deny        (deny),
        .alarm       (alarm),
        .attempts    (attempts)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000ns");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each observed event is {event, attempts} and must match the queue head.
    task automatic score(input logic [1:0] ev);
        logic [3:0] got;
        logic [3:0] exp;
        got = {ev, attempts};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %0h expected none", got);
        end else begin
            exp = exp_q.pop_front();
            check("event", 8'(got), 8'(exp));
        end
    endtask

    logic granted_d;
    logic alarm_d;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            granted_d <= 1'b0;
            alarm_d   <= 1'b0;
        end else begin
            if (granted && !granted_d) score(EV_GRANT);
            if (deny) score(EV_DENY);
            if (alarm && !alarm_d) score(EV_ALARM);
            granted_d <= granted;
            alarm_d   <= alarm;
        end
    end

    // Driver tasks (called at a falling edge)
    task automatic press(input logic is_clear, input logic [3:0] sw, input logic p, input int hold);
        sw_code = sw;
        prog    = p;
        if (is_clear) btn_clear = 1'b1;
        else          btn_confirm = 1'b1;
        repeat (hold) @(negedge clk);
        btn_clear   = 1'b0;
        btn_confirm = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 8'(exp_q.size()), 8'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_entered"}, 8'(entered_code), 8'h0);
        check({tag, "_stored"}, 8'(stored_code), 8'hA);
        check({tag, "_sel"}, 8'(sel), 8'd0);
        check({tag, "_granted"}, 8'(granted), 8'd0);
        check({tag, "_deny"}, 8'(deny), 8'd0);
        check({tag, "_alarm"}, 8'(alarm), 8'd0);
        check({tag, "_attempts"}, 8'(attempts), 8'd0);
    endtask

    typedef struct {
        logic       clr;
        logic [3:0] sw;
        logic       prog;
        int         hold;
        logic [3:0] e_entered;
        logic [3:0] e_stored;
        logic       e_granted;
        logic [1:0] att;
        logic [1:0] evt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        int alarm_len;

        // Starting state for the table: IDLE, entered=A, stored=A, attempts=0.
        vecs.push_back('{1'b0, 4'hA, 1'b0, 8,  4'hA, 4'hA, 1'b1, 2'd0, EV_GRANT});
        vecs.push_back('{1'b0, 4'h6, 1'b1, 8,  4'hA, 4'h6, 1'b1, 2'd0, EV_NONE});
        vecs.push_back('{1'b0, 4'h3, 1'b0, 8,  4'hA, 4'h6, 1'b1, 2'd0, EV_NONE});
        vecs.push_back('{1'b1, 4'h3, 1'b0, 8,  4'hA, 4'h6, 1'b0, 2'd0, EV_NONE});
        vecs.push_back('{1'b1, 4'h3, 1'b0, 8,  4'h0, 4'h6, 1'b0, 2'd0, EV_NONE});
        vecs.push_back('{1'b0, 4'hA, 1'b0, 8,  4'hA, 4'h6, 1'b0, 2'd1, EV_DENY});
        vecs.push_back('{1'b0, 4'h6, 1'b0, 8,  4'h6, 4'h6, 1'b1, 2'd0, EV_GRANT});
        vecs.push_back('{1'b1, 4'h6, 1'b0, 8,  4'h6, 4'h6, 1'b0, 2'd0, EV_NONE});
        vecs.push_back('{1'b0, 4'h1, 1'b0, 20, 4'h1, 4'h6, 1'b0, 2'd1, EV_DENY});
        vecs.push_back('{1'b0, 4'h1, 1'b0, 8,  4'h1, 4'h6, 1'b0, 2'd2, EV_DENY});
`ifndef SECCODE_LOCKOUT_EN
        vecs.push_back('{1'b0, 4'h1, 1'b0, 8,  4'h1, 4'h6, 1'b0, 2'd3, EV_DENY});
        vecs.push_back('{1'b0, 4'h1, 1'b0, 8,  4'h1, 4'h6, 1'b0, 2'd3, EV_DENY});
        vecs.push_back('{1'b0, 4'h6, 1'b0, 8,  4'h6, 4'h6, 1'b1, 2'd0, EV_GRANT});
`endif

        reset       = 1'b1;
        sw_code     = 4'h0;
        btn_confirm = 1'b0;
        btn_clear   = 1'b0;
        prog        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // Free-running select: first toggle at edge SCAN_DIV after release.
        for (int e = 1; e <= 3 * SCAN_DIV; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("sel_e%0d", e), 8'(sel), 8'((e / SCAN_DIV) % 2));
        end
        check("idle_granted", 8'(granted), 8'd0);
        check("idle_attempts", 8'(attempts), 8'd0);

        // Simultaneous confirm+clear: clear wins, nothing captured.
        sw_code     = 4'hF;
        btn_confirm = 1'b1;
        btn_clear   = 1'b1;
        repeat (10) @(negedge clk);
        btn_confirm = 1'b0;
        btn_clear   = 1'b0;
        repeat (6) @(negedge clk);
        check("both_entered", 8'(entered_code), 8'h0);

        // Two-cycle glitch is shorter than the debounce window.
        btn_confirm = 1'b1;
        repeat (2) @(negedge clk);
        btn_confirm = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_entered", 8'(entered_code), 8'h0);
        check("glitch_attempts", 8'(attempts), 8'd0);

        // Latency: accept in cycle 5, capture at edge 6, granted from edge 7.
        sw_code = 4'hA;
        prog    = 1'b0;
        exp_q.push_back({EV_GRANT, 2'd0});
        btn_confirm = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 5) check("lat_entered_e5", 8'(entered_code), 8'h0);
            if (e == 6) begin
                check("lat_entered_e6", 8'(entered_code), 8'hA);
                check("lat_granted_e6", 8'(granted), 8'd0);
            end
            if (e == 7) check("lat_granted_e7", 8'(granted), 8'd1);
        end
        btn_confirm = 1'b0;
        repeat (4) @(negedge clk);
        drain("lat_drain");
        press(1'b1, 4'h0, 1'b0, 8);
        check("lat_clear_granted", 8'(granted), 8'd0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].evt != EV_NONE) exp_q.push_back({vecs[i].evt, vecs[i].att});
            press(vecs[i].clr, vecs[i].sw, vecs[i].prog, vecs[i].hold);
            drain($sformatf("v%0d_events", i));
            check($sformatf("v%0d_entered", i), 8'(entered_code), 8'(vecs[i].e_entered));
            check($sformatf("v%0d_stored", i), 8'(stored_code), 8'(vecs[i].e_stored));
            check($sformatf("v%0d_granted", i), 8'(granted), 8'(vecs[i].e_granted));
            check($sformatf("v%0d_attempts", i), 8'(attempts), 8'(vecs[i].att));
            check($sformatf("v%0d_alarm", i), 8'(alarm), 8'd0);
        end

`ifdef SECCODE_LOCKOUT_EN
        // Third failure locks out for LOCK_CYCLES; a press during lockout is ignored.
        exp_q.push_back({EV_ALARM, 2'd3});
        sw_code     = 4'h1;
        prog        = 1'b0;
        btn_confirm = 1'b1;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (alarm) begin
                lat = i;
                break;
            end
        end
        check("alarm_latency", 8'(lat), 8'd7);
        alarm_len = 0;
        for (int i = 0; i < 40; i++) begin
            if (!alarm) break;
            alarm_len++;
            if (alarm_len == 2) btn_confirm = 1'b0;
            if (alarm_len == 4) begin
                sw_code     = 4'h6;
                btn_confirm = 1'b1;
            end
            if (alarm_len == 12) btn_confirm = 1'b0;
            @(negedge clk);
        end
        btn_confirm = 1'b0;
        check("alarm_len", 8'(alarm_len), 8'(LOCK_CYCLES));
        check("lock_exit_attempts", 8'(attempts), 8'd0);
        check("lock_exit_granted", 8'(granted), 8'd0);
        repeat (10) @(negedge clk);
        check("lock_ignored_granted", 8'(granted), 8'd0);
        check("lock_ignored_entered", 8'(entered_code), 8'h1);
        drain("lock_drain");

        exp_q.push_back({EV_GRANT, 2'd0});
        press(1'b0, 4'h6, 1'b0, 8);
        drain("post_lock_grant");
        check("post_lock_granted", 8'(granted), 8'd1);
        press(1'b0, 4'hF, 1'b1, 8);
        check("prog_F_stored", 8'(stored_code), 8'hF);
        press(1'b1, 4'h0, 1'b0, 8);
        exp_q.push_back({EV_DENY, 2'd1});
        press(1'b0, 4'h1, 1'b0, 8);
        exp_q.push_back({EV_DENY, 2'd2});
        press(1'b0, 4'h1, 1'b0, 8);
        drain("second_denies");

        // Reset asserted mid-lockout, off the clock edge.
        exp_q.push_back({EV_ALARM, 2'd3});
        btn_confirm = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (alarm) break;
        end
        repeat (3) @(negedge clk);
        drain("pre_reset_alarm");
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("lock_rst");
`else
        // Reset asserted while granted with a programmed code: code is lost.
        press(1'b0, 4'hF, 1'b1, 8);
        check("prog_F_stored", 8'(stored_code), 8'hF);
        drain("pre_reset");
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("grant_rst");
`endif
        btn_confirm = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/security_code_capture.md
# security_code_capture

Keypad/switch code-entry controller for the digital security system. It debounces the confirm and clear buttons, captures a 4-bit code from switches, and compares it against a stored 4-bit code. It grants or denies access, counts failed attempts and locks out after repeated failures. It drives the two 4-bit code sets (entered, stored) and the free-running select line that the downstream 8x4 display multiplexer consumes.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized-high cycles needed to accept a button press (≥1).
- SCAN_DIV, 8: cycles between toggles of `sel` (≥1).
- MAX_TRIES, 3: failed attempts that trigger lockout (1–3).
- LOCK_CYCLES, 16: lockout duration in cycles (≥1).
- RESET_CODE, 4'b1010: stored code after reset.

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- sw_code  in  4: code switches, bit 3 = MSB; level-sampled.
- btn_confirm  in  1: raw confirm button, active-high, asynchronous.
- btn_clear  in  1: raw clear button, active-high, asynchronous.
- prog  in  1: 1 = a confirm while granted reprograms the stored code.
- entered_code  out  4: last captured code (set L0 to the mux).
- stored_code  out  4: current stored code (set L1 to the mux).
- sel  out  1: display select to the mux (0 = entered, 1 = stored).
- granted  out  1: high while in GRANT.
- deny  out  1: one-cycle pulse on a failed attempt.
- alarm  out  1: high while in LOCKOUT.
- attempts  out  2: consecutive failed attempts.

## Operation
- Each button passes through a 2-FF synchronizer, then a debounce counter.
- The counter produces a one-cycle accept pulse when the synchronized level has been 1 for DEBOUNCE_CYCLES consecutive cycles.
- After a pulse, the button re-arms only after at least one synchronized-low cycle. Holding the button yields exactly one pulse.
- FSM states: IDLE, COMPARE, GRANT, DENY, LOCKOUT.
- IDLE
  - Confirm accept: entered_code <= sw_code, go to COMPARE.
  - Clear accept: entered_code <= 0.
- COMPARE (1 cycle)
  - entered_code == stored_code: attempts <= 0, go to GRANT.
  - Otherwise: attempts <= attempts+1, go to DENY, or to LOCKOUT per Configuration.
- GRANT: `granted`=1.
  - Confirm accept with prog=1: stored_code <= sw_code; stay in GRANT.
  - Confirm accept with prog=0: ignored.
  - Clear accept: go to IDLE.
- DENY (1 cycle): `deny`=1, then go to IDLE.
- LOCKOUT: `alarm`=1. A down-counter loaded with LOCK_CYCLES runs while in this state. All accepts are ignored. When the counter expires, attempts <= 0 and the FSM goes to IDLE.
- Simultaneous confirm and clear accept in the same cycle: clear wins, confirm is discarded.
- `attempts` saturates at 3.
- `sel` scan counter is free-running in every state. `sel` toggles each time the counter reaches SCAN_DIV-1, then the counter wraps to 0.

## Timing
- Reset values
  - entered_code = 0, stored_code = RESET_CODE, sel = 0.
  - granted = deny = alarm = 0, attempts = 0.
  - FSM = IDLE; debounce, scan and lock counters = 0.
- Reset asserted mid-operation (any state, including LOCKOUT or mid-debounce) aborts immediately; a programmed code is lost.
- Button latency: raw rise sampled at edge 0 → accept pulse high in cycle 1+DEBOUNCE_CYCLES (2 sync + DEBOUNCE_CYCLES−1).
- Accept → entered_code updated at the next edge. COMPARE takes one cycle, so granted/deny/alarm assert 2 cycles after the accept pulse.
- `deny` is exactly one cycle wide.
- LOCKOUT lasts exactly LOCK_CYCLES cycles, then IDLE.
- `sel` period is 2·SCAN_DIV cycles; first toggle at edge SCAN_DIV after reset release.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: SECCODE_LOCKOUT_EN.
- Defined: a failure whose new attempt count equals MAX_TRIES goes COMPARE → LOCKOUT instead of DENY. No deny pulse is issued for that attempt.
- Undefined: LOCKOUT state and lock counter are not built; every failure goes to DENY; `alarm` is tied 0; attempts still count and saturate.

## Test plan
- Reset release, no inputs → stored_code=1010, entered_code=0, sel toggles every 8 cycles, all flags 0.
- sw_code=1010, confirm held 20 cycles → single accept; entered_code=1010; granted=1 two cycles after accept; attempts=0.
- In GRANT, prog=1, sw_code=0110, confirm → stored_code=0110. Then clear → IDLE; sw_code=0110 confirm → granted again.
- With SECCODE_LOCKOUT_EN: three confirms with sw_code=0001 → first two produce deny pulses (attempts 1, 2); third gives alarm=1 for 16 cycles with confirms ignored, then attempts=0, IDLE.
- Same three failures without the macro → three deny pulses, attempts=3, alarm stays 0.
- Confirm and clear rising together, and a 2-cycle glitch on confirm → no capture. Reset asserted in LOCKOUT → all outputs to reset values immediately.
